mem_port_arbiter: RTL and testbench

- Shares the single-port 8-bit data memory between two requesters:
  - port 0: processor data side (MemRead/MemWrite path)
  - port 1: program loader / debug port
- Sits between the requesters and the memory block.
- Registered round-robin grant, with optional burst lock and a hold cap so neither port starves.
- Read data returns one cycle after the granted cycle, matching the memory's registered-address read latency.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter_rr_pick2.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Owner encoding is used by both the top level and the next-owner chooser.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  function automatic logic [1:0] owner_to_gnt(input owner_e owner);
    logic [1:0] gnt;
    gnt = 2'b00;
    if (owner == OWN_P0) gnt = 2'b01;
    if (owner == OWN_P1) gnt = 2'b10;
    return gnt;
  endfunction

  function automatic owner_e port_to_owner(input logic port);
    return port ? OWN_P1 : OWN_P0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundle for the arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_port_arbiter_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_port_arbiter_pkg::DATA_W_DEF
);

  logic [1:0]        req;
  logic [1:0]        lock;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req, lock, we, addr0, addr1, wdata0, wdata1, mem_q,
    output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wren, mem_rden
  );

  modport master (
    output req, lock, we, addr0, addr1, wdata0, wdata1, mem_q,
    input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wren, mem_rden
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational next-owner chooser: locked owner retention with a hold cap,
// then round-robin between two requesters, then the single requester.
module rr_pick2
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  owner_e     owner,
  input  logic       last_served,
  input  logic [3:0] hold_cnt,
  output owner_e     next_owner
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

  logic own_idx;
  logic other_idx;
  logic keep;

  always_comb begin
    own_idx    = (owner == OWN_P1);
    other_idx  = ~own_idx;
    keep       = 1'b0;
    next_owner = OWN_NONE;

    // The cap only bites while the other port is actually waiting.
    if (owner != OWN_NONE) begin
      keep = req[own_idx] & lock[own_idx] &
             ((hold_cnt < HOLD_LIMIT) | ~req[other_idx]);
    end

    if (keep) begin
      next_owner = owner;
    end else if (req == 2'b11) begin
      next_owner = port_to_owner(~last_served);
    end else if (req[0]) begin
      next_owner = OWN_P0;
    end else if (req[1]) begin
      next_owner = OWN_P1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port data memory: registered grant,
// combinational memory-side mux, and one-cycle read-valid return.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  owner_e     owner_q;
  owner_e     owner_d;
  logic       last_served_q;
  logic       last_served_d;
  logic [3:0] hold_cnt_q;
  logic [3:0] hold_cnt_d;
  logic [1:0] rd_pend_q;
  logic [1:0] rd_pend_d;

  logic       own_idx;
  logic       access;
  logic       last_served_eff;
  owner_e     pick_owner;

  // An access this cycle counts as served now, so the tie-break already
  // sees it and two unlocked requesters alternate every cycle.
  always_comb begin
    own_idx         = (owner_q == OWN_P1);
    access          = (owner_q != OWN_NONE) & bus.req[own_idx];
    last_served_eff = access ? own_idx : last_served_q;
  end

  rr_pick2 #(
    .MAX_HOLD (MAX_HOLD)
  ) u_pick (
    .req         (bus.req),
    .lock        (bus.lock),
    .owner       (owner_q),
    .last_served (last_served_eff),
    .hold_cnt    (hold_cnt_q),
    .next_owner  (pick_owner)
  );

  always_comb begin
    owner_d       = pick_owner;
    last_served_d = last_served_eff;
    hold_cnt_d    = hold_cnt_q;
    rd_pend_d     = 2'b00;

    if ((pick_owner == OWN_NONE) || (pick_owner != owner_q)) begin
      hold_cnt_d = 4'd0;
    end else if (access && (hold_cnt_q != 4'hF)) begin
      hold_cnt_d = hold_cnt_q + 4'd1;
    end

    if (access && !bus.we[own_idx]) begin
      rd_pend_d[own_idx] = 1'b1;
    end
  end

  always_comb begin
    bus.gnt       = owner_to_gnt(owner_q);
    bus.rvalid    = rd_pend_q;
    bus.rdata     = bus.mem_q;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wren  = 1'b0;
    bus.mem_rden  = 1'b0;

    if (owner_q != OWN_NONE) begin
      bus.mem_addr  = own_idx ? bus.addr1 : bus.addr0;
      bus.mem_wdata = own_idx ? bus.wdata1 : bus.wdata0;
      bus.mem_wren  = access & bus.we[own_idx];
      bus.mem_rden  = access & ~bus.we[own_idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q       <= OWN_NONE;
      last_served_q <= 1'b1;
      hold_cnt_q    <= 4'd0;
      rd_pend_q     <= 2'b00;
    end else begin
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      hold_cnt_q    <= hold_cnt_d;
      rd_pend_q     <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a registered-read memory model.
// Expected read returns are queued at the access cycle and popped when rvalid shows up.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_port_arbiter #(
    .MAX_HOLD (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [256];

  always @(posedge clock) begin
    if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rden) bus.mem_q <= mem[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] l,
                                input logic [1:0] w, input logic [7:0] a0,
                                input logic [7:0] d0, input logic [7:0] a1,
                                input logic [7:0] d1);
    bus.req    = r;
    bus.lock   = l;
    bus.we     = w;
    bus.addr0  = a0;
    bus.wdata0 = d0;
    bus.addr1  = a1;
    bus.wdata1 = d1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    apply_stimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Every rvalid must match the oldest outstanding expected read.
  always @(negedge clock) begin
    logic [9:0] e;
    if (!reset && bus.rvalid !== 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL spurious_rvalid: got rvalid=%b rdata=%h, expected none at %0t",
                 bus.rvalid, bus.rdata, $time);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rvalid, bus.rdata} !== e) begin
          errors++;
          $display("[TB] FAIL read_return: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h at %0t",
                   bus.rvalid, bus.rdata, e[9:8], e[7:0], $time);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h1A] = 8'h5C;
    mem[8'h10] = 8'h11;
    mem[8'h20] = 8'h22;
    mem[8'h40] = 8'h44;
    mem[8'h03] = 8'h00;
    apply_stimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_output("reset_gnt", 32'(bus.gnt), 32'h0);
    check_output("reset_rvalid", 32'(bus.rvalid), 32'h0);
    check_output("reset_wren", 32'(bus.mem_wren), 32'h0);
    check_output("reset_rden", 32'(bus.mem_rden), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;

    $display("[TB] reset during locked port-1 burst");
    apply_stimulus(2'b10, 2'b10, 2'b10, 8'h00, 8'h00, 8'h60, 8'h66);
    next_cycle();
    @(negedge clock);
    check_output("t1_gnt_p1", 32'(bus.gnt), 32'h2);
    check_output("t1_wren", 32'(bus.mem_wren), 32'h1);
    next_cycle();
    #2 reset = 1'b1;
    #1;
    check_output("t1_async_gnt", 32'(bus.gnt), 32'h0);
    check_output("t1_async_rvalid", 32'(bus.rvalid), 32'h0);
    check_output("t1_async_wren", 32'(bus.mem_wren), 32'h0);
    check_output("t1_async_rden", 32'(bus.mem_rden), 32'h0);
    @(posedge clock);
    #1;
    apply_stimulus(2'b11, 2'b00, 2'b11, 8'h70, 8'h77, 8'h71, 8'h78);
    reset = 1'b0;
    @(negedge clock);
    check_output("t1_idle_gnt", 32'(bus.gnt), 32'h0);
    next_cycle();
    @(negedge clock);
    check_output("t1_first_gnt", 32'(bus.gnt), 32'h1);
    next_cycle();
    apply_stimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    check_output("t1_second_gnt", 32'(bus.gnt), 32'h2);
    check_output("t1_withdraw_wren", 32'(bus.mem_wren), 32'h0);
    next_cycle();

    $display("[TB] single read");
    apply_stimulus(2'b01, 2'b00, 2'b00, 8'h1A, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    check_output("t2_gnt_before", 32'(bus.gnt), 32'h0);
    next_cycle();
    @(negedge clock);
    check_output("t2_gnt", 32'(bus.gnt), 32'h1);
    check_output("t2_rden", 32'(bus.mem_rden), 32'h1);
    check_output("t2_wren", 32'(bus.mem_wren), 32'h0);
    check_output("t2_addr", 32'(bus.mem_addr), 32'h1A);
    exp_q.push_back({2'b01, 8'h5C});
    next_cycle();
    apply_stimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    check_output("t2_rvalid", 32'(bus.rvalid), 32'h1);
    check_output("t2_rdata", 32'(bus.rdata), 32'h5C);
    check_output("t2_withdraw_rden", 32'(bus.mem_rden), 32'h0);
    next_cycle();
    @(negedge clock);
    check_output("t2_gnt_after", 32'(bus.gnt), 32'h0);
    check_output("t2_rvalid_after", 32'(bus.rvalid), 32'h0);

    $display("[TB] unlocked contention");
    do_reset();
    apply_stimulus(2'b11, 2'b00, 2'b00, 8'h10, 8'h00, 8'h20, 8'h00);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clock);
      check_output("t3_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) check_output("t3_rvalid", 32'(bus.rvalid), (k % 2 == 0) ? 32'h2 : 32'h1);
      exp_q.push_back((k % 2 == 0) ? {2'b01, 8'h11} : {2'b10, 8'h22});
    end
    next_cycle();
    apply_stimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    check_output("t3_last_rvalid", 32'(bus.rvalid), 32'h2);
    repeat (2) next_cycle();

    $display("[TB] locked burst with hold cap");
    do_reset();
    apply_stimulus(2'b11, 2'b01, 2'b11, 8'h30, 8'hAA, 8'h31, 8'hBB);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      @(negedge clock);
      check_output("t4_gnt", 32'(bus.gnt), (k < 4) ? 32'h1 : 32'h2);
      check_output("t4_wren", 32'(bus.mem_wren), 32'h1);
    end
    next_cycle();
    apply_stimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) next_cycle();

    $display("[TB] lock without contention");
    do_reset();
    apply_stimulus(2'b01, 2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 9; k++) begin
      next_cycle();
      @(negedge clock);
      check_output("t5_gnt", 32'(bus.gnt), 32'h1);
      exp_q.push_back({2'b01, 8'h44});
    end
    next_cycle();
    apply_stimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) next_cycle();

    $display("[TB] withdrawn request, then write/read-back");
    do_reset();
    apply_stimulus(2'b01, 2'b00, 2'b00, 8'h50, 8'h00, 8'h00, 8'h00);
    next_cycle();
    apply_stimulus(2'b00, 2'b00, 2'b00, 8'h50, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    check_output("t6_wd_gnt", 32'(bus.gnt), 32'h1);
    check_output("t6_wd_wren", 32'(bus.mem_wren), 32'h0);
    check_output("t6_wd_rden", 32'(bus.mem_rden), 32'h0);
    next_cycle();
    @(negedge clock);
    check_output("t6_wd_rvalid", 32'(bus.rvalid), 32'h0);
    check_output("t6_wd_gnt_after", 32'(bus.gnt), 32'h0);
    apply_stimulus(2'b10, 2'b00, 2'b10, 8'h00, 8'h00, 8'h03, 8'hA5);
    next_cycle();
    @(negedge clock);
    check_output("t6_wr_gnt", 32'(bus.gnt), 32'h2);
    check_output("t6_wr_wren", 32'(bus.mem_wren), 32'h1);
    check_output("t6_wr_addr", 32'(bus.mem_addr), 32'h03);
    check_output("t6_wr_data", 32'(bus.mem_wdata), 32'hA5);
    next_cycle();
    apply_stimulus(2'b01, 2'b00, 2'b00, 8'h03, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    check_output("t6_p1_withdraw_wren", 32'(bus.mem_wren), 32'h0);
    next_cycle();
    @(negedge clock);
    check_output("t6_rd_gnt", 32'(bus.gnt), 32'h1);
    check_output("t6_rd_rden", 32'(bus.mem_rden), 32'h1);
    check_output("t6_rd_addr", 32'(bus.mem_addr), 32'h03);
    exp_q.push_back({2'b01, 8'hA5});
    next_cycle();
    apply_stimulus(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    check_output("t6_rd_rvalid", 32'(bus.rvalid), 32'h1);
    check_output("t6_rd_rdata", 32'(bus.rdata), 32'hA5);
    repeat (3) next_cycle();

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
